// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one small FIFO with bypass per producer (ALU, LSB),
// round-robin tie break and a registered single-result broadcast per cycle.
module cdb_arbiter #(
    parameter int ROB_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    input  logic             alu_has_new_pc,
    input  logic [31:0]      alu_new_pc,
    output logic             alu_stall,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             lsb_stall,
    output logic             cdb_valid,
    output logic             cdb_src,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value,
    output logic             cdb_has_new_pc,
    output logic [31:0]      cdb_new_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      value;
        logic             has_new_pc;
        logic [31:0]      new_pc;
    } alu_ent_t;

    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      value;
    } lsb_ent_t;

    alu_ent_t        alu_mem [DEPTH];
    lsb_ent_t        lsb_mem [DEPTH];
    logic [PW-1:0]   alu_head, alu_tail, lsb_head, lsb_tail;
    logic [CW-1:0]   alu_cnt, lsb_cnt, alu_cnt_next, lsb_cnt_next;
    logic            rr, rr_next;

    alu_ent_t        alu_in, alu_cand;
    lsb_ent_t        lsb_in, lsb_cand;
    logic            alu_byp, alu_req, alu_gnt, alu_push, alu_pop;
    logic            lsb_byp, lsb_req, lsb_gnt, lsb_push, lsb_pop;

    always_comb begin
        alu_in   = '{rob_id: alu_rob_id, value: alu_value,
                     has_new_pc: alu_has_new_pc, new_pc: alu_new_pc};
        lsb_in   = '{rob_id: lsb_rob_id, value: lsb_value};

        alu_byp  = (alu_cnt == '0) && alu_valid;
        lsb_byp  = (lsb_cnt == '0) && lsb_valid;
        alu_req  = (alu_cnt != '0) || alu_valid;
        lsb_req  = (lsb_cnt != '0) || lsb_valid;
        alu_cand = alu_byp ? alu_in : alu_mem[alu_head];
        lsb_cand = lsb_byp ? lsb_in : lsb_mem[lsb_head];

        // rr only matters, and only advances, when both sources compete
        lsb_gnt  = lsb_req && (!alu_req || rr);
        alu_gnt  = alu_req && !lsb_gnt;
        rr_next  = (alu_req && lsb_req) ? alu_gnt : rr;

        // a losing bypass still lands in the FIFO; pushes into a full FIFO are dropped
        alu_push = alu_valid && !(alu_byp && alu_gnt) && (alu_cnt != CW'(DEPTH));
        lsb_push = lsb_valid && !(lsb_byp && lsb_gnt) && (lsb_cnt != CW'(DEPTH));
        alu_pop  = alu_gnt && !alu_byp;
        lsb_pop  = lsb_gnt && !lsb_byp;

        alu_cnt_next = alu_cnt + CW'(alu_push) - CW'(alu_pop);
        lsb_cnt_next = lsb_cnt + CW'(lsb_push) - CW'(lsb_pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || rob_clear) begin
            alu_head       <= '0;
            alu_tail       <= '0;
            alu_cnt        <= '0;
            lsb_head       <= '0;
            lsb_tail       <= '0;
            lsb_cnt        <= '0;
            rr             <= 1'b0;
            alu_stall      <= 1'b0;
            lsb_stall      <= 1'b0;
            cdb_valid      <= 1'b0;
            cdb_src        <= 1'b0;
            cdb_rob_id     <= '0;
            cdb_value      <= '0;
            cdb_has_new_pc <= 1'b0;
            cdb_new_pc     <= '0;
        end else if (rdy_in) begin
            if (alu_push) alu_mem[alu_tail] <= alu_in;
            if (lsb_push) lsb_mem[lsb_tail] <= lsb_in;
            alu_tail  <= alu_tail + PW'(alu_push);
            lsb_tail  <= lsb_tail + PW'(lsb_push);
            alu_head  <= alu_head + PW'(alu_pop);
            lsb_head  <= lsb_head + PW'(lsb_pop);
            alu_cnt   <= alu_cnt_next;
            lsb_cnt   <= lsb_cnt_next;
            rr        <= rr_next;
            alu_stall <= alu_cnt_next >= CW'(DEPTH - 1);
            lsb_stall <= lsb_cnt_next >= CW'(DEPTH - 1);
            cdb_valid <= alu_req || lsb_req;
            if (alu_gnt) begin
                cdb_src        <= 1'b0;
                cdb_rob_id     <= alu_cand.rob_id;
                cdb_value      <= alu_cand.value;
                cdb_has_new_pc <= alu_cand.has_new_pc;
                cdb_new_pc     <= alu_cand.new_pc;
            end else if (lsb_gnt) begin
                cdb_src        <= 1'b1;
                cdb_rob_id     <= lsb_cand.rob_id;
                cdb_value      <= lsb_cand.value;
                cdb_has_new_pc <= 1'b0;
                cdb_new_pc     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed vector table plus short
// hand-written reset / flush sequences.
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear;
    logic        alu_valid, alu_has_new_pc, lsb_valid;
    logic [3:0]  alu_rob_id, lsb_rob_id;
    logic [31:0] alu_value, alu_new_pc, lsb_value;
    logic        alu_stall, lsb_stall;
    logic        cdb_valid, cdb_src, cdb_has_new_pc;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value, cdb_new_pc;

    int checks = 0;
    int errors = 0;
    int row    = -1;

    cdb_arbiter #(.ROB_W(4), .DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .alu_has_new_pc(alu_has_new_pc), .alu_new_pc(alu_new_pc), .alu_stall(alu_stall),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .lsb_stall(lsb_stall), .cdb_valid(cdb_valid), .cdb_src(cdb_src),
        .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cdb_has_new_pc(cdb_has_new_pc), .cdb_new_pc(cdb_new_pc)
    );

    always #5 clk_in = ~clk_in;

    // Producers must never push into a FIFO that already holds DEPTH entries
    always @(posedge clk_in) begin
        if (!rst_in && !rob_clear && rdy_in) begin
            assert (!(alu_valid && int'(dut.alu_cnt) == 4)) else $error("push into full ALU queue");
            assert (!(lsb_valid && int'(dut.lsb_cnt) == 4)) else $error("push into full LSB queue");
        end
    end

    typedef struct {
        logic       rdy, clr, av;
        logic [3:0] aid;
        logic       anpc, lv;
        logic [3:0] lid;
        logic       ev, esrc;
        logic [3:0] eid;
        logic       enpc, eas, els;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] val(input logic s, input logic [3:0] id);
        return (s ? 32'hB000_0000 : 32'hA000_0000) | 32'(id);
    endfunction

    task automatic add(input int rdy, input int clr, input int av, input int aid,
                       input int anpc, input int lv, input int lid, input int ev,
                       input int esrc, input int eid, input int enpc, input int eas,
                       input int els);
        vec_t t;
        t.rdy = (rdy != 0);  t.clr = (clr != 0);  t.av = (av != 0);
        t.aid = 4'(aid);     t.anpc = (anpc != 0); t.lv = (lv != 0);
        t.lid = 4'(lid);     t.ev = (ev != 0);    t.esrc = (esrc != 0);
        t.eid = 4'(eid);     t.enpc = (enpc != 0); t.eas = (eas != 0);
        t.els = (els != 0);
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; rob_clear = 1'b0;
        alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0;
        alu_has_new_pc = 1'b0; alu_new_pc = '0;
        lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(cdb_valid), 0);
        chk({nm, "_src"}, 32'(cdb_src), 0);
        chk({nm, "_id"}, 32'(cdb_rob_id), 0);
        chk({nm, "_value"}, cdb_value, 0);
        chk({nm, "_hnpc"}, 32'(cdb_has_new_pc), 0);
        chk({nm, "_npc"}, cdb_new_pc, 0);
        chk({nm, "_astall"}, 32'(alu_stall), 0);
        chk({nm, "_lstall"}, 32'(lsb_stall), 0);
    endtask

    initial begin
        // pairwise contention, rr = 0 then rr = 1
        add(1,0, 1,1,0, 1,2,  1,0,1,0, 0,0);
        add(1,0, 0,0,0, 0,0,  1,1,2,0, 0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0, 0,0);
        add(1,0, 1,4,0, 1,5,  1,1,5,0, 0,0);
        add(1,0, 0,0,0, 0,0,  1,0,4,0, 0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0, 0,0);
        // both producers push every cycle, honouring stall
        add(1,0, 1,0,0, 1,8,  1,0,0,0,  0,0);
        add(1,0, 1,1,0, 1,9,  1,1,8,0,  0,0);
        add(1,0, 1,2,0, 1,10, 1,0,1,0,  0,0);
        add(1,0, 1,3,0, 1,11, 1,1,9,0,  0,0);
        add(1,0, 1,4,0, 1,12, 1,0,2,0,  0,1);
        add(1,0, 1,5,0, 0,0,  1,1,10,0, 1,0);
        add(1,0, 0,0,0, 1,13, 1,0,3,0,  0,1);
        add(1,0, 1,6,0, 0,0,  1,1,11,0, 1,0);
        add(1,0, 0,0,0, 0,0,  1,0,4,0,  0,0);
        add(1,0, 0,0,0, 0,0,  1,1,12,0, 0,0);
        add(1,0, 0,0,0, 0,0,  1,0,5,0,  0,0);
        add(1,0, 0,0,0, 0,0,  1,1,13,0, 0,0);
        add(1,0, 0,0,0, 0,0,  1,0,6,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        // fill the ALU queue to 4 across pointer wrap, then drain
        add(1,0, 1,0,0, 1,9,  1,0,0,0,  0,0);
        add(1,0, 1,1,0, 1,10, 1,1,9,0,  0,0);
        add(1,0, 1,2,0, 1,11, 1,0,1,0,  0,0);
        add(1,0, 1,3,0, 0,0,  1,1,10,0, 0,0);
        add(1,0, 1,4,0, 0,0,  1,0,2,0,  0,0);
        add(1,0, 1,5,0, 0,0,  1,1,11,0, 1,0);
        add(1,0, 0,0,0, 1,12, 1,0,3,0,  0,0);
        add(1,0, 1,6,0, 0,0,  1,1,12,0, 1,0);
        add(1,0, 1,7,0, 1,13, 1,0,4,0,  1,0);
        add(1,0, 1,8,0, 0,0,  1,1,13,0, 1,0);
        add(1,0, 0,0,0, 0,0,  1,0,5,0,  1,0);
        add(1,0, 0,0,0, 0,0,  1,0,6,0,  0,0);
        add(1,0, 0,0,0, 0,0,  1,0,7,0,  0,0);
        add(1,0, 0,0,0, 0,0,  1,0,8,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        // queue 3 LSB entries, then flush
        add(1,0, 1,0,0, 1,1,  1,0,0,0,  0,0);
        add(1,0, 1,2,0, 1,3,  1,1,1,0,  0,0);
        add(1,0, 0,0,0, 1,4,  1,0,2,0,  0,0);
        add(1,0, 1,5,0, 1,6,  1,1,3,0,  0,0);
        add(1,0, 0,0,0, 1,7,  1,0,5,0,  0,1);
        add(1,1, 0,0,0, 1,8,  0,0,0,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        add(1,0, 1,9,0, 1,10, 1,0,9,0,  0,0);
        add(1,0, 0,0,0, 0,0,  1,1,10,0, 0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        // rdy_in gating and jalr redirect
        add(0,0, 1,3,1, 0,0,  0,0,0,0,  0,0);
        add(0,0, 1,3,1, 0,0,  0,0,0,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        add(1,0, 1,3,1, 0,0,  1,0,3,1,  0,0);
        add(0,0, 0,0,0, 1,4,  1,0,3,1,  0,0);
        add(0,0, 0,0,0, 0,0,  1,0,3,1,  0,0);
        add(1,0, 0,0,0, 1,4,  1,1,4,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);
        // flush while frozen still discards the queued ALU entry
        add(1,0, 1,6,0, 1,7,  1,1,7,0,  0,0);
        add(0,1, 0,0,0, 0,0,  0,0,0,0,  0,0);
        add(1,0, 0,0,0, 0,0,  0,0,0,0,  0,0);

        idle_inputs();
        rst_in = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst_in = 1'b0;

        alu_valid = 1'b1; alu_rob_id = 4'd3; alu_value = 32'h11;
        step();
        idle_inputs();
        chk("single_valid", 32'(cdb_valid), 1);
        chk("single_src", 32'(cdb_src), 0);
        chk("single_id", 32'(cdb_rob_id), 3);
        chk("single_value", cdb_value, 32'h11);
        step();
        chk("single_drop", 32'(cdb_valid), 0);

        foreach (vecs[i]) begin
            row = i;
            rdy_in         = vecs[i].rdy;
            rob_clear      = vecs[i].clr;
            alu_valid      = vecs[i].av;
            alu_rob_id     = vecs[i].aid;
            alu_value      = val(1'b0, vecs[i].aid);
            alu_has_new_pc = vecs[i].anpc;
            alu_new_pc     = vecs[i].anpc ? 32'h1000 : 32'h0;
            lsb_valid      = vecs[i].lv;
            lsb_rob_id     = vecs[i].lid;
            lsb_value      = val(1'b1, vecs[i].lid);
            step();
            chk("valid", 32'(cdb_valid), 32'(vecs[i].ev));
            chk("alu_stall", 32'(alu_stall), 32'(vecs[i].eas));
            chk("lsb_stall", 32'(lsb_stall), 32'(vecs[i].els));
            if (vecs[i].ev) begin
                chk("src", 32'(cdb_src), 32'(vecs[i].esrc));
                chk("rob_id", 32'(cdb_rob_id), 32'(vecs[i].eid));
                chk("value", cdb_value, val(vecs[i].esrc, vecs[i].eid));
                chk("has_new_pc", 32'(cdb_has_new_pc), 32'(vecs[i].enpc));
            end
            if (vecs[i].enpc) chk("new_pc", cdb_new_pc, 32'h1000);
        end
        row = -1;

        // reset mid-operation drops the queued LSB entry and same-cycle inputs
        idle_inputs();
        alu_valid = 1'b1; alu_rob_id = 4'd1; alu_value = val(1'b0, 4'd1);
        lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = val(1'b1, 4'd2);
        step();
        chk("pre_rst_id", 32'(cdb_rob_id), 1);
        alu_rob_id = 4'd5; lsb_rob_id = 4'd6;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        idle_inputs();
        chk_zero("mid_rst");
        step();
        chk("post_rst_idle", 32'(cdb_valid), 0);
        lsb_valid = 1'b1; lsb_rob_id = 4'd7; lsb_value = val(1'b1, 4'd7);
        step();
        idle_inputs();
        chk("post_rst_src", 32'(cdb_src), 1);
        chk("post_rst_id", 32'(cdb_rob_id), 7);
        step();
        chk("post_rst_end", 32'(cdb_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
